// File: rtl/operand_fetch_pkg.sv
// Shared constants and state encoding for the operand-fetch stage and its scoreboard.
package operand_fetch_pkg;

    localparam int DATA_WIDTH  = 32;
    localparam int REG_NUM     = 32;
    localparam int REG_NUM_BIT = 5;

    localparam logic [REG_NUM_BIT-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        DATA  = 2'd2,
        VALID = 2'd3
    } state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// One busy bit per architectural register, marking destinations with a write still in flight.
module rf_scoreboard #(
    parameter int REG_NUM     = operand_fetch_pkg::REG_NUM,
    parameter int REG_NUM_BIT = operand_fetch_pkg::REG_NUM_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   set_en_i,
    input  logic [REG_NUM_BIT-1:0] set_idx_i,
    input  logic                   clr_en_i,
    input  logic [REG_NUM_BIT-1:0] clr_idx_i,
    input  logic [REG_NUM_BIT-1:0] q_a_idx_i,
    input  logic [REG_NUM_BIT-1:0] q_b_idx_i,
    input  logic [REG_NUM_BIT-1:0] q_d_idx_i,
    output logic                   busy_a_o,
    output logic                   busy_b_o,
    output logic                   busy_d_o,
    output logic [REG_NUM-1:0]     busy_vec_o
);

    logic [REG_NUM-1:0] busy_q, busy_d;

    // The set is applied after the clear so a new writer claiming a register wins over an older retiring write.
    always_comb begin
        busy_d = busy_q;
        if (clr_en_i) busy_d[clr_idx_i] = 1'b0;
        if (set_en_i) busy_d[set_idx_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign busy_a_o   = busy_q[q_a_idx_i];
    assign busy_b_o   = busy_q[q_b_idx_i];
    assign busy_d_o   = busy_q[q_d_idx_i];
    assign busy_vec_o = busy_q;

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: issues register-file reads, stalls on RAW/WAW hazards and bypasses writeback data.
module operand_fetch #(
    parameter int DATA_WIDTH  = operand_fetch_pkg::DATA_WIDTH,
    parameter int REG_NUM     = operand_fetch_pkg::REG_NUM,
    parameter int REG_NUM_BIT = operand_fetch_pkg::REG_NUM_BIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_NUM_BIT-1:0] in_rs1,
    input  logic [REG_NUM_BIT-1:0] in_rs2,
    input  logic [REG_NUM_BIT-1:0] in_rd,
    input  logic                   in_rd_wen,
    output logic [REG_NUM_BIT-1:0] raddr_a,
    output logic [REG_NUM_BIT-1:0] raddr_b,
    input  logic [DATA_WIDTH-1:0]  rdata_a,
    input  logic [DATA_WIDTH-1:0]  rdata_b,
    input  logic                   wb_valid,
    input  logic [REG_NUM_BIT-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]  wb_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_rs1_val,
    output logic [DATA_WIDTH-1:0]  out_rs2_val,
    output logic [REG_NUM_BIT-1:0] out_rd,
    output logic                   out_rd_wen,
    output logic [31:0]            stall_cnt
);
    import operand_fetch_pkg::*;

    state_e state_q, state_d;

    logic [REG_NUM_BIT-1:0] rs1_q, rs2_q, rd_q;
    logic                   rd_wen_q;
    logic [DATA_WIDTH-1:0]  byp_a_q, byp_b_q;
    logic                   flag_a_q, flag_b_q;
    logic                   out_valid_q;
    logic [DATA_WIDTH-1:0]  out_rs1_q, out_rs2_q;
    logic [REG_NUM_BIT-1:0] out_rd_q;
    logic                   out_rd_wen_q;
    logic [31:0]            stall_cnt_q;

    logic                   busyA, busyB, busyD;
    logic [REG_NUM-1:0]     busy_vec;
    logic                   acceptEn, hazard, bypHitA, bypHitB, setEn;

    assign in_ready = (state_q == IDLE) || (state_q == VALID && out_ready);
    assign acceptEn = in_valid && in_ready && !flush;
    assign bypHitA  = wb_valid && (wb_rd == rs1_q);
    assign bypHitB  = wb_valid && (wb_rd == rs2_q);
    assign hazard   = (busyA && !bypHitA) || (busyB && !bypHitB) || (rd_wen_q && busyD);
    assign setEn    = (state_q == DATA) && rd_wen_q && (rd_q != REG_ZERO) && !flush;

    assign raddr_a     = rs1_q;
    assign raddr_b     = rs2_q;
    assign out_valid   = out_valid_q;
    assign out_rs1_val = out_rs1_q;
    assign out_rs2_val = out_rs2_q;
    assign out_rd      = out_rd_q;
    assign out_rd_wen  = out_rd_wen_q;
    assign stall_cnt   = stall_cnt_q;

    rf_scoreboard #(
        .REG_NUM     (REG_NUM),
        .REG_NUM_BIT (REG_NUM_BIT)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (setEn),
        .set_idx_i  (rd_q),
        .clr_en_i   (wb_valid),
        .clr_idx_i  (wb_rd),
        .q_a_idx_i  (rs1_q),
        .q_b_idx_i  (rs2_q),
        .q_d_idx_i  (rd_q),
        .busy_a_o   (busyA),
        .busy_b_o   (busyB),
        .busy_d_o   (busyD),
        .busy_vec_o (busy_vec)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (acceptEn) state_d = CHECK;
            CHECK:   if (!hazard) state_d = DATA;
            DATA:    state_d = VALID;
            VALID:   if (out_ready) state_d = acceptEn ? CHECK : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // The register file returns the pre-write value on the edge a writeback lands, so that data is captured here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_q        <= '0;
            rs2_q        <= '0;
            rd_q         <= '0;
            rd_wen_q     <= 1'b0;
            byp_a_q      <= '0;
            byp_b_q      <= '0;
            flag_a_q     <= 1'b0;
            flag_b_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_rs1_q    <= '0;
            out_rs2_q    <= '0;
            out_rd_q     <= '0;
            out_rd_wen_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            if (acceptEn) begin
                rs1_q    <= in_rs1;
                rs2_q    <= in_rs2;
                rd_q     <= in_rd;
                rd_wen_q <= in_rd_wen;
            end
            if (state_q == CHECK && !flush) begin
                if (hazard) begin
                    if (stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 32'd1;
                end else begin
                    flag_a_q <= bypHitA && (rs1_q != REG_ZERO);
                    flag_b_q <= bypHitB && (rs2_q != REG_ZERO);
                    byp_a_q  <= wb_data;
                    byp_b_q  <= wb_data;
                end
            end
            if (state_q == DATA && !flush) begin
                out_rs1_q    <= (rs1_q == REG_ZERO) ? '0 : (flag_a_q ? byp_a_q : rdata_a);
                out_rs2_q    <= (rs2_q == REG_ZERO) ? '0 : (flag_b_q ? byp_b_q : rdata_b);
                out_rd_q     <= rd_q;
                out_rd_wen_q <= rd_wen_q;
                out_valid_q  <= 1'b1;
            end else if (state_q == VALID && out_ready) begin
                out_valid_q  <= 1'b0;
            end
            if (flush) begin
                out_valid_q <= 1'b0;
                flag_a_q    <= 1'b0;
                flag_b_q    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural registered-read register file.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_wen;
    logic [4:0]  raddr_a, raddr_b;
    logic [31:0] rdata_a, rdata_b;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic [31:0] stall_cnt;

    logic [31:0] rf [32];
    int          errorCount = 0;
    int          checkCount = 0;
    int          acceptCount;

    operand_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .raddr_a     (raddr_a),
        .raddr_b     (raddr_b),
        .rdata_a     (rdata_a),
        .rdata_b     (rdata_b),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_rs1_val (out_rs1_val),
        .out_rs2_val (out_rs2_val),
        .out_rd      (out_rd),
        .out_rd_wen  (out_rd_wen),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    // Register file: x1=5, x2=7, others 0x100+index, x0 hardwired to zero; reads return the pre-write value.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'h100 + i;
            rf[0] <= 32'h0;
            rf[1] <= 32'd5;
            rf[2] <= 32'd7;
        end else if (wb_valid && wb_rd != 5'd0) begin
            rf[wb_rd] <= wb_data;
        end
        rdata_a <= rf[raddr_a];
        rdata_b <= rf[raddr_b];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rdWen);
        in_valid  = v;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_rd     = rd;
        in_rd_wen = rdWen;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(); tick();
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_rs1_val", out_rs1_val, 32'd0);
        checkOutput("reset_stall_cnt", stall_cnt, 32'd0);
        checkOutput("reset_raddr_a", {27'd0, raddr_a}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic issue rs1=1, rs2=2, rd=3
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd3, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        checkOutput("basic_raddr_a", {27'd0, raddr_a}, 32'd1);
        checkOutput("basic_raddr_b", {27'd0, raddr_b}, 32'd2);
        checkOutput("basic_valid_c1", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("basic_valid_c2", {31'd0, out_valid}, 32'd0);
        tick();
        checkOutput("basic_valid_c3", {31'd0, out_valid}, 32'd1);
        checkOutput("basic_rs1_val", out_rs1_val, 32'd5);
        checkOutput("basic_rs2_val", out_rs2_val, 32'd7);
        checkOutput("basic_rd", {27'd0, out_rd}, 32'd3);
        checkOutput("basic_rd_wen", {31'd0, out_rd_wen}, 32'd1);
        checkOutput("basic_busy3", {31'd0, dut.busy_vec[3]}, 32'd1);
        checkOutput("basic_in_ready_held", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        #1;
        checkOutput("basic_in_ready_go", {31'd0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b0;
        checkOutput("basic_valid_drop", {31'd0, out_valid}, 32'd0);

        // RAW on x3 held 4 cycles, then bypass of 0xAB
        applyStimulus(1'b1, 5'd3, 5'd2, 5'd4, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        repeat (4) tick();
        checkOutput("raw_stalled_valid", {31'd0, out_valid}, 32'd0);
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hAB;
        tick();
        wb_valid = 1'b0;
        checkOutput("raw_stall_cnt", stall_cnt, 32'd4);
        tick();
        checkOutput("raw_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("raw_bypass_rs1", out_rs1_val, 32'hAB);
        checkOutput("raw_rs2", out_rs2_val, 32'd7);
        checkOutput("raw_busy3_clear", {31'd0, dut.busy_vec[3]}, 32'd0);
        checkOutput("raw_busy4_set", {31'd0, dut.busy_vec[4]}, 32'd1);
        out_ready = 1'b1;
        tick();

        // Make x5 busy, then WAW on rd=5
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(); tick(); tick();
        out_ready = 1'b0;
        checkOutput("waw_prep_busy5", {31'd0, dut.busy_vec[5]}, 32'd1);
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd5, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick(); tick();
        checkOutput("waw_stall_cnt", stall_cnt, 32'd6);
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'h55;
        tick();
        checkOutput("waw_busy5_cleared", {31'd0, dut.busy_vec[5]}, 32'd0);
        checkOutput("waw_still_stalled", {31'd0, out_valid}, 32'd0);
        tick(); tick();
        wb_valid = 1'b0;
        checkOutput("waw_set_wins", {31'd0, dut.busy_vec[5]}, 32'd1);
        checkOutput("waw_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("waw_rd", {27'd0, out_rd}, 32'd5);
        checkOutput("waw_stall_final", stall_cnt, 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Source x0 with writeback to x0
        applyStimulus(1'b1, 5'd0, 5'd1, 5'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFF;
        tick();
        wb_valid = 1'b0;
        tick();
        checkOutput("x0_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("x0_rs1_val", out_rs1_val, 32'd0);
        checkOutput("x0_rs2_val", out_rs2_val, 32'd5);
        checkOutput("x0_busy0", {31'd0, dut.busy_vec[0]}, 32'd0);
        checkOutput("x0_no_stall", stall_cnt, 32'd7);
        out_ready = 1'b1;
        tick();

        // Back-to-back with out_ready held high: one accept every 3 cycles
        acceptCount = 0;
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd6, 1'b0);
        for (int i = 0; i < 9; i++) begin
            if (in_ready) acceptCount++;
            tick();
        end
        checkOutput("b2b_accepts", acceptCount, 32'd3);
        checkOutput("b2b_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("hold_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("hold_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("hold_rs1_val", out_rs1_val, 32'd5);
            checkOutput("hold_rs2_val", out_rs2_val, 32'd7);
            checkOutput("hold_rd", {27'd0, out_rd}, 32'd6);
        end
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("b2b_drain_valid", {31'd0, out_valid}, 32'd0);

        // Flush while stalled on x4
        applyStimulus(1'b1, 5'd4, 5'd2, 5'd7, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("flush_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_busy4_kept", {31'd0, dut.busy_vec[4]}, 32'd1);
        checkOutput("flush_busy7_none", {31'd0, dut.busy_vec[7]}, 32'd0);
        checkOutput("flush_stall_cnt", stall_cnt, 32'd8);

        // Asynchronous reset while in DATA
        applyStimulus(1'b1, 5'd1, 5'd2, 5'd8, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("arst_rs1_val", out_rs1_val, 32'd0);
        checkOutput("arst_rs2_val", out_rs2_val, 32'd0);
        checkOutput("arst_rd", {27'd0, out_rd}, 32'd0);
        checkOutput("arst_stall_cnt", stall_cnt, 32'd0);
        checkOutput("arst_busy4", {31'd0, dut.busy_vec[4]}, 32'd0);
        checkOutput("arst_raddr_a", {27'd0, raddr_a}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        checkOutput("post_arst_in_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("post_arst_valid", {31'd0, out_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
